audio_pll_reset_sequencer: RTL
==============================

// Module: audio_pll_reset_sequencer
// PURPOSE
//   Drives the audio PLL reset and qualifies its lock output. Runs on the 50 MHz PLL reference clock.
//   Controls PLL reset pulsing, lock debounce, lock-timeout retry and loss-of-lock recovery.
//   Releases audio_reset_n to the 18.432 MHz audio domain only after lock is stable.
//   The audio domain re-synchronises audio_reset_n itself.
// PARAMETERS
//   RST_PULSE_CYCLES    16     cycles pll_rst is held high per reset attempt (>=1)
//   LOCK_STABLE_CYCLES  1024   consecutive synced-locked cycles required before ready (>=1)
//   LOCK_TIMEOUT_CYCLES 50000  max cycles waiting for lock per attempt (1 ms @ 50 MHz)
//   MAX_RETRIES         4      consecutive timed-out attempts before FAIL (>=1)
//   CNT_W               16     width of internal cycle counter; must hold the largest *_CYCLES value
// PORTS
//   clk            in   1  50 MHz reference clock (same net as PLL refclk)
//   reset_n        in   1  asynchronous active-low reset
//   restart        in   1  single-cycle pulse: force a fresh sequence from any state
//   pll_locked     in   1  PLL locked output, asynchronous; synchronised internally
//   pll_rst        out  1  to PLL rst, active high
//   audio_reset_n  out  1  low until lock qualified; high only in RUN
//   ready          out  1  high only in RUN
//   fail           out  1  high only in FAIL
// BEHAVIOUR
//   - Reset values: pll_rst=1, audio_reset_n=0, ready=0, fail=0, state=PULSE, cnt=0, retries=0.
//   - pll_locked passes through a 2-FF synchroniser (lk_s). All decisions use lk_s, adding 2 cycles of latency.
//   - All outputs are registered and decoded from the state register.
//   - States:
//     PULSE: pll_rst=1; cnt counts 0..RST_PULSE_CYCLES-1; then cnt=0 -> WAIT.
//       pll_rst is high for exactly RST_PULSE_CYCLES cycles per entry.
//     WAIT: pll_rst=0; cnt++ each cycle.
//       lk_s=1 -> STABLE, cnt=0.
//       cnt reaches LOCK_TIMEOUT_CYCLES-1 without lock -> retries++:
//         if retries+1==MAX_RETRIES -> FAIL;
//         else -> PULSE.
//     STABLE: cnt++ while lk_s=1.
//       lk_s=0 -> WAIT, cnt=0 (glitch; no retry consumed).
//       cnt reaches LOCK_STABLE_CYCLES-1 -> RUN, retries=0.
//     RUN: ready=1, audio_reset_n=1.
//       lk_s=0 -> PULSE, cnt=0. ready and audio_reset_n fall on the next edge.
//     FAIL: fail=1, pll_rst=1 (PLL held in reset). Leaves only on restart.
//   - restart has priority over every transition in the same cycle:
//     -> PULSE, cnt=0, retries=0; ready/audio_reset_n drop next edge.
//   - Simultaneous lk_s loss and stable-count terminal in STABLE: loss wins -> WAIT.
//   - Simultaneous lock arrival and timeout terminal in WAIT: lock wins -> STABLE.
//   - Counters saturate and never wrap. retries is wide enough for MAX_RETRIES.
//   - Asserting reset_n mid-sequence returns all outputs to reset values asynchronously.
// CONFIGURATION
//   AUDIO_PLL_SEQ_STATUS_EN defined:
//     - Adds output lock_lost_count [7:0].
//     - Increments on every RUN->PULSE transition caused by lk_s=0 (not by restart).
//     - Saturates at 8'hFF; cleared only by reset_n.
//     - Adds output attempt_count [7:0] = retries, zero-extended.
//   Not defined: both ports and their logic are absent. All other behaviour is identical.
// TESTING  (bench params: RST_PULSE=4, LOCK_STABLE=8, TIMEOUT=32, MAX_RETRIES=2)
//   - Release reset_n; PLL model asserts locked 10 cycles after pll_rst falls:
//     pll_rst high 4 cycles; ready rises 10+2+8 (+/-1) cycles after pll_rst falls.
//   - Locked never asserts:
//     two 4-cycle pll_rst pulses, each followed by a 32-cycle WAIT;
//     then fail=1 and pll_rst=1 held; restart pulse -> fresh 4-cycle sequence.
//   - In STABLE, drop locked for 1 cycle at stable count 5:
//     returns to WAIT without a new pll_rst pulse; ready only after 8 clean cycles.
//   - In RUN, drop locked:
//     ready and audio_reset_n low 3 cycles later, 4-cycle pll_rst pulse;
//     with STATUS_EN, lock_lost_count 0->1.
//   - restart in the same cycle as the WAIT timeout terminal:
//     PULSE entered, retries=0, fail never asserted.
//   - Assert reset_n low mid-RUN:
//     ready=0, audio_reset_n=0 and pll_rst=1 immediately (asynchronous).

Source files
------------

// File: rtl/audio_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// audio_pll_reset_sequencer
//
// Purpose:
//   Runs on the 50 MHz PLL reference clock. Pulses the audio PLL reset,
//   debounces the PLL lock indication, retries the PLL when lock does not
//   arrive in time, and recovers from loss of lock. audio_reset_n is released
//   to the 18.432 MHz audio domain only once lock has been stable for
//   LOCK_STABLE_CYCLES. The audio domain re-synchronises audio_reset_n itself.
//
// Ports:
//   clk             in   reference clock (same net as PLL refclk)
//   reset_n         in   asynchronous active-low reset
//   restart         in   single-cycle pulse, forces a fresh sequence from any state
//   pll_locked      in   PLL lock output, asynchronous (2-FF synchronised here)
//   pll_rst         out  PLL reset, active high (high in PULSE and FAIL)
//   audio_reset_n   out  audio-domain reset, high only in RUN
//   ready           out  high only in RUN
//   fail            out  high only in FAIL
//   state           out  debug view of the FSM state register
//   lock_lost_count out  [7:0] RUN->PULSE events caused by lock loss (optional)
//   attempt_count   out  [7:0] consecutive timed-out attempts (optional)
//
// Configuration macro:
//   AUDIO_PLL_SEQ_STATUS_EN  adds lock_lost_count and attempt_count.
//
// restart is a level sampled on every clk edge; it carries no handshake and
// overrides every other transition in the cycle it is high.
// -----------------------------------------------------------------------------
module audio_pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES         = 4,
  parameter int CNT_W               = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       restart,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       audio_reset_n,
  output logic       ready,
  output logic       fail,
`ifdef AUDIO_PLL_SEQ_STATUS_EN
  output logic [7:0] lock_lost_count,
  output logic [7:0] attempt_count,
`endif
  output logic [2:0] state
);

  localparam int RET_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [RET_W-1:0] RETRY_LAST   = RET_W'(MAX_RETRIES - 1);
  localparam logic [RET_W-1:0] RETRY_MAX    = '1;

  typedef enum logic [2:0] {
    S_PULSE  = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [RET_W-1:0] retries_q, retries_d, retries_inc;
  logic             lk_meta, lk_s;

  // Two-stage synchroniser for the asynchronous lock signal.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk_s    <= lk_meta;
    end
  end

  // Saturating increments: counters never wrap.
  assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign retries_inc = (retries_q == RETRY_MAX) ? retries_q : retries_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_PULSE;
      cnt_q     <= '0;
      retries_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    if (restart) begin
      state_d   = S_PULSE;
      cnt_d     = '0;
      retries_d = '0;
    end else begin
      case (state_q)
        S_PULSE: begin
          if (cnt_q >= PULSE_LAST) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_WAIT: begin
          // Lock arriving on the timeout terminal cycle still wins.
          if (lk_s) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q >= TIMEOUT_LAST) begin
            cnt_d     = '0;
            retries_d = retries_inc;
            state_d   = (retries_q >= RETRY_LAST) ? S_FAIL : S_PULSE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_STABLE: begin
          // A lock drop is a glitch: back to WAIT without spending a retry.
          // It also wins over the stable-count terminal.
          if (!lk_s) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else if (cnt_q >= STABLE_LAST) begin
            state_d   = S_RUN;
            cnt_d     = '0;
            retries_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_RUN: begin
          if (!lk_s) begin
            state_d = S_PULSE;
            cnt_d   = '0;
          end
        end
        S_FAIL: begin
          cnt_d = '0;
        end
        default: begin
          state_d = S_PULSE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered off the next state so they line up with state_q
  // and never glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pll_rst       <= 1'b1;
      audio_reset_n <= 1'b0;
      ready         <= 1'b0;
      fail          <= 1'b0;
    end else begin
      pll_rst       <= (state_d == S_PULSE) || (state_d == S_FAIL);
      audio_reset_n <= (state_d == S_RUN);
      ready         <= (state_d == S_RUN);
      fail          <= (state_d == S_FAIL);
    end
  end

  assign state = state_q;

`ifdef AUDIO_PLL_SEQ_STATUS_EN
  logic lost_evt;

  // Only lock loss in RUN counts; a restart in RUN is not a lock loss.
  assign lost_evt = !restart && (state_q == S_RUN) && !lk_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_lost_count <= 8'h00;
    end else if (lost_evt && (lock_lost_count != 8'hFF)) begin
      lock_lost_count <= lock_lost_count + 8'd1;
    end
  end

  assign attempt_count = 8'(retries_q);
`endif

endmodule
